// File: rtl/fe_fetch.sv
// Instruction fetch front end: PC register, ROM addressing and a 2-entry fetch queue.
// Optional performance counters are enabled with `define FE_FETCH_PERF_EN.
package Purple_Jade_pkg;
   parameter int WORD_SIZE_P   = 32;
   parameter int I_ROM_DEPTH_P = 64;
endpackage

module fe_fetch
   import Purple_Jade_pkg::*;
#(
   parameter int RESET_PC_P = 0,
   localparam int ADDR_WIDTH_LP = $clog2(I_ROM_DEPTH_P)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   output logic [ADDR_WIDTH_LP-1:0] rom_addr_o,
   input  logic [WORD_SIZE_P-1:0]   rom_data_i,
   input  logic                     redirect_v_i,
   input  logic [ADDR_WIDTH_LP-1:0] redirect_pc_i,
   input  logic                     halt_i,
   output logic                     instr_v_o,
   output logic [WORD_SIZE_P-1:0]   instr_o,
   output logic [ADDR_WIDTH_LP-1:0] instr_pc_o,
   input  logic                     decode_ready_i,
   output logic [31:0]              perf_fetch_cnt_o,
   output logic [31:0]              perf_redirect_cnt_o
);

   typedef struct packed {
      logic [WORD_SIZE_P-1:0]   instr;
      logic [ADDR_WIDTH_LP-1:0] pc;
   } fe_entry_t;

   localparam logic [ADDR_WIDTH_LP-1:0] RESET_PC_LP = ADDR_WIDTH_LP'(RESET_PC_P);
   localparam logic [ADDR_WIDTH_LP-1:0] LAST_PC_LP  = ADDR_WIDTH_LP'(I_ROM_DEPTH_P - 1);

   logic [ADDR_WIDTH_LP-1:0] pc_r;
   logic [ADDR_WIDTH_LP-1:0] pc_inc;
   fe_entry_t                mem_r [2];
   logic                     rd_ptr_r;
   logic                     wr_ptr_r;
   logic [1:0]               count_r;
   logic                     pop;
   logic                     push;

   assign rom_addr_o = pc_r;
   assign instr_v_o  = (count_r != 2'd0);
   assign instr_o    = mem_r[rd_ptr_r].instr;
   assign instr_pc_o = mem_r[rd_ptr_r].pc;

   assign pop    = instr_v_o & decode_ready_i;
   assign push   = ~halt_i & ~redirect_v_i & ((count_r < 2'd2) | pop);
   assign pc_inc = (pc_r == LAST_PC_LP) ? '0 : pc_r + 1'b1;

   // Redirect wins over everything: it drops queued entries and any pop.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pc_r     <= RESET_PC_LP;
         rd_ptr_r <= 1'b0;
         wr_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else if (redirect_v_i) begin
         pc_r     <= redirect_pc_i;
         rd_ptr_r <= 1'b0;
         wr_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push) begin
            pc_r     <= pc_inc;
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (pop) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         unique case ({push, pop})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_r[wr_ptr_r] <= '{instr: rom_data_i, pc: pc_r};
      end
   end

`ifdef FE_FETCH_PERF_EN
   logic [31:0] fetch_cnt_r;
   logic [31:0] redirect_cnt_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fetch_cnt_r    <= '0;
         redirect_cnt_r <= '0;
      end else begin
         if (push) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
         end
         if (redirect_v_i) begin
            redirect_cnt_r <= redirect_cnt_r + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt_o    = fetch_cnt_r;
   assign perf_redirect_cnt_o = redirect_cnt_r;
`else
   assign perf_fetch_cnt_o    = '0;
   assign perf_redirect_cnt_o = '0;
`endif

endmodule

// File: doc/fe_fetch.md
FE_FETCH -- requirements
Module: fe_fetch

Interface
REQ-001 SHALL have parameter RESET_PC_P, default 0, the ROM word address fetched first after reset.
REQ-002 SHALL derive ADDR_WIDTH_LP = $clog2(I_ROM_DEPTH_P); WORD_SIZE_P and I_ROM_DEPTH_P come from Purple_Jade_pkg.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk_i input 1 rising-edge clock, reset_n_i input 1 async active-low reset.
REQ-004 SHALL have rom_addr_o, output, ADDR_WIDTH_LP: word address driven to the instruction ROM.
REQ-005 SHALL have rom_data_i, input, WORD_SIZE_P: instruction returned combinationally by the ROM for rom_addr_o.
REQ-006 SHALL have redirect_v_i (input, 1) and redirect_pc_i (input, ADDR_WIDTH_LP): backend branch/jump redirect.
REQ-007 SHALL have halt_i, input, 1: level-sensitive fetch stall.
REQ-008 SHALL have instr_v_o (output, 1), instr_o (output, WORD_SIZE_P), instr_pc_o (output, ADDR_WIDTH_LP): head instruction to decode.
REQ-009 SHALL have decode_ready_i, input, 1: decode accepts the head entry when instr_v_o & decode_ready_i.
REQ-010 SHALL have perf_fetch_cnt_o and perf_redirect_cnt_o, outputs, 32 each: performance counters.

Function
REQ-011 SHALL drive rom_addr_o = pc_r continuously.
REQ-012 SHALL hold fetched {instruction, pc} pairs in a 2-entry FIFO; instr_o/instr_pc_o/instr_v_o reflect the oldest entry; instr_v_o = (count != 0).
REQ-013 SHALL pop the head when instr_v_o & decode_ready_i.
REQ-014 SHALL push {rom_data_i, pc_r} when ~halt_i & ~redirect_v_i & (count < 2 | pop); push and pop in one cycle leave count unchanged.
REQ-015 SHALL advance pc_r by 1 on every push; pc_r = I_ROM_DEPTH_P-1 wraps to 0.
REQ-016 SHALL hold pc_r and FIFO contents when the push condition is false and no redirect occurs.
REQ-017 SHALL on redirect_v_i: flush all FIFO entries (count <= 0, including any popped this cycle), load pc_r <= redirect_pc_i, push nothing; instr_v_o is 0 the next cycle.
REQ-018 SHALL give redirect_v_i priority over halt_i, push and pop.
REQ-019 SHALL have fetch-to-decode latency of one cycle: word at pc_r in cycle N is visible on instr_o in cycle N+1 if the FIFO was empty.
REQ-020 SHALL sustain one instruction per cycle when decode_ready_i stays high.
REQ-021 SHALL keep FIFO head stable while instr_v_o & ~decode_ready_i.

Reset
REQ-022 SHALL on reset_n_i low asynchronously set pc_r = RESET_PC_P, count = 0, FIFO pointers = 0, counters = 0; instr_v_o = 0, rom_addr_o = RESET_PC_P.
REQ-023 SHALL discard all in-flight entries if reset asserts mid-operation; FIFO data storage need not be reset.
REQ-024 SHALL begin fetching at the first rising clk_i after reset_n_i deasserts.

Configuration
REQ-025 SHALL, with macro FE_FETCH_PERF_EN defined, increment perf_fetch_cnt_o per push and perf_redirect_cnt_o per cycle with redirect_v_i high, both wrapping modulo 2^32.
REQ-026 SHALL, without FE_FETCH_PERF_EN, keep both ports present and tied to 0 with no counter registers.

Verification
REQ-027 Reset, RESET_PC_P=0, decode_ready_i=1 -> rom_addr_o 0,1,2,3 on cycles 1-4 after reset release; instr_pc_o 0,1,2 on cycles 2-4.
REQ-028 decode_ready_i=0 for 5 cycles from empty -> exactly 2 entries (pc 0,1) held, rom_addr_o stalls at 2, instr_pc_o stays 0.
REQ-029 FIFO full (pc 4,5), redirect_v_i=1 with redirect_pc_i=20 and decode_ready_i=1 -> next cycle instr_v_o=0, rom_addr_o=20; following cycle instr_pc_o=20.
REQ-030 pc_r at I_ROM_DEPTH_P-1, ready=1 -> next rom_addr_o=0; instr_pc_o shows I_ROM_DEPTH_P-1 then 0.
REQ-031 halt_i=1 and redirect_v_i=1 (redirect_pc_i=7) same cycle -> pc_r=7, FIFO empty; with halt_i still 1 no push; halt_i=0 -> pc 7 pushed.
REQ-032 With FE_FETCH_PERF_EN, 10 pushes and 2 redirects -> perf_fetch_cnt_o=10, perf_redirect_cnt_o=2; without the macro both read 0.
